mmio_router: RTL and testbench

Parametrised MMIO decoder/sequencer between the core data port and `NUM_SLV` memory-mapped peripherals (UART, display, LEDs, timers). Replaces the fixed-address UART/display taps in the memory controller with a windowed slave array that handles variable-latency peripherals. It stalls the core via `mem_hold` until the slave acknowledges. It also byte-aligns read data and reports decode errors and timeouts. Non-MMIO accesses are passed through untouched by the memory controller; this block ignores them.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_lane_align.sv | 23 ++
 rtl/mmio_router.sv | 169 ++++++++++++++++
 tb/tb_mmio_router.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO router and its helpers.
package mmio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStrobe,
        StWait,
        StErr,
        StDone
    } mmio_state_t;

    localparam logic [31:0] MMIO_ERR_DATA  = 32'hFFFF_FFFF;
    localparam logic [19:0] MMIO_BASE_DFLT = 20'haaaaa;

endpackage

// File: rtl/mmio_lane_align.sv
// Byte-lane shifter: places the low byte of a slave word on the lane addressed by the core.
module mmio_lane_align (
    input  logic [31:0] din_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] dout_o
);

    // Slaves return byte data in the low lane; the upper bits are deliberately dropped.
    logic unused_upper;
    assign unused_upper = ^din_i[31:8];

    always_comb begin
        dout_o = '0;
        unique case (lane_i)
            2'd0: dout_o = {24'h0, din_i[7:0]};
            2'd1: dout_o = {16'h0, din_i[7:0], 8'h0};
            2'd2: dout_o = {8'h0, din_i[7:0], 16'h0};
            2'd3: dout_o = {din_i[7:0], 24'h0};
            default: dout_o = '0;
        endcase
    end

endmodule

// File: rtl/mmio_router.sv
// Windowed MMIO decoder/sequencer: strobes one slave per core access and stalls the core
// until that slave acknowledges, times out, or the address decodes to no slave.
module mmio_router
    import mmio_pkg::*;
#(
    parameter logic [19:0] MMIO_BASE = MMIO_BASE_DFLT,
    parameter int unsigned NUM_SLV   = 4,
    parameter int unsigned WIN_BITS  = 8,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           mem_addr_i,
    input  logic                  mem_wea_i,
    input  logic                  mem_rea_i,
    input  logic [31:0]           mem_din_i,
    output logic [31:0]           mem_dout_o,
    output logic                  mem_hold_o,
    output logic                  mmio_err_o,
    output logic [NUM_SLV-1:0]    slv_wen_o,
    output logic [NUM_SLV-1:0]    slv_ren_o,
    output logic [WIN_BITS-1:0]   slv_addr_o,
    output logic [31:0]           slv_din_o,
    input  logic [NUM_SLV*32-1:0] slv_dout_i,
    input  logic [NUM_SLV-1:0]    slv_ack_i
);

    localparam int unsigned IdxW = 12 - WIN_BITS;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    mmio_state_t         state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                we_q, we_d;
    logic [1:0]          lane_q, lane_d;
    logic [WIN_BITS-1:0] addr_q, addr_d;
    logic [31:0]         din_q, din_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [IdxW-1:0]     req_idx;
    logic                req;
    logic                dec_err;
    logic                ack_sel;
    logic [31:0]         dout_sel;
    logic [31:0]         rdata_aligned;

    assign req_idx = mem_addr_i[11:WIN_BITS];
    assign req     = (mem_wea_i | mem_rea_i) && (mem_addr_i[31:12] == MMIO_BASE);
    assign dec_err = 32'(req_idx) >= NUM_SLV;

    // Only the latched slave's ack and data are ever looked at.
    always_comb begin
        ack_sel  = 1'b0;
        dout_sel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IdxW'(i)) begin
                ack_sel  = slv_ack_i[i];
                dout_sel = slv_dout_i[32*i +: 32];
            end
        end
    end

    mmio_lane_align u_lane_align (
        .din_i  (rdata_q),
        .lane_i (lane_q),
        .dout_o (rdata_aligned)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            lane_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (dec_err) begin
                        state_d = StErr;
                    end else begin
                        state_d = StStrobe;
                        idx_d   = req_idx;
                        we_d    = mem_wea_i;
                        lane_d  = mem_addr_i[1:0];
                        addr_d  = mem_addr_i[WIN_BITS-1:0];
                        din_d   = mem_din_i;
                    end
                end
            end
            StStrobe: begin
                cnt_d = '0;
                if (ack_sel) begin
                    rdata_d = dout_sel;
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (ack_sel) begin
                    rdata_d = dout_sel;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntW'(TIMEOUT)) begin
                        state_d = StErr;
                    end
                end
            end
            StErr:   state_d = StIdle;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_hold_o = 1'b0;
        mmio_err_o = 1'b0;
        mem_dout_o = '0;
        slv_wen_o  = '0;
        slv_ren_o  = '0;
        unique case (state_q)
            StIdle: mem_hold_o = req;
            StStrobe: begin
                mem_hold_o = 1'b1;
                for (int unsigned i = 0; i < NUM_SLV; i++) begin
                    slv_wen_o[i] = we_q && (idx_q == IdxW'(i));
                    slv_ren_o[i] = !we_q && (idx_q == IdxW'(i));
                end
            end
            StWait: mem_hold_o = 1'b1;
            StErr: begin
                mmio_err_o = 1'b1;
                mem_dout_o = MMIO_ERR_DATA;
            end
            StDone:  mem_dout_o = we_q ? 32'h0 : rdata_aligned;
            default: mem_hold_o = 1'b0;
        endcase
    end

    assign slv_addr_o = addr_q;
    assign slv_din_o  = din_q;

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router with default parameters (4 slaves, 256 B windows, timeout 15).
module tb_mmio_router;

    logic         clk;
    logic         rst;
    logic [31:0]  mem_addr;
    logic         mem_wea;
    logic         mem_rea;
    logic [31:0]  mem_din;
    logic [31:0]  mem_dout;
    logic         mem_hold;
    logic         mmio_err;
    logic [3:0]   slv_wen;
    logic [3:0]   slv_ren;
    logic [7:0]   slv_addr;
    logic [31:0]  slv_din;
    logic [127:0] slv_dout;
    logic [3:0]   slv_ack;

    int n_checks = 0;
    int n_errors = 0;

    mmio_router u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mem_addr_i (mem_addr),
        .mem_wea_i  (mem_wea),
        .mem_rea_i  (mem_rea),
        .mem_din_i  (mem_din),
        .mem_dout_o (mem_dout),
        .mem_hold_o (mem_hold),
        .mmio_err_o (mmio_err),
        .slv_wen_o  (slv_wen),
        .slv_ren_o  (slv_ren),
        .slv_addr_o (slv_addr),
        .slv_din_o  (slv_din),
        .slv_dout_i (slv_dout),
        .slv_ack_i  (slv_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One core access; ack_dly < 0 means the target slave never acks.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic we,
                          input logic re, input logic [31:0] wdata, input int ack_slv,
                          input int ack_dly, input logic [31:0] rdata, input int exp_hold,
                          input logic [3:0] exp_wen, input logic [3:0] exp_ren,
                          input logic exp_err, input logic [31:0] exp_dout,
                          input logic [7:0] exp_saddr);
        logic        done;
        int          hold_cnt;
        int          strb_cnt;
        int          err_cnt;
        logic [3:0]  wen_acc;
        logic [3:0]  ren_acc;
        logic [7:0]  saddr_s;
        logic [31:0] sdin_s;
        logic [31:0] dout_s;
        logic [127:0] bus;
        done = 1'b0;
        hold_cnt = 0;
        strb_cnt = 0;
        err_cnt = 0;
        wen_acc = '0;
        ren_acc = '0;
        saddr_s = '0;
        sdin_s = '0;
        dout_s = '0;
        for (int i = 0; i < 4; i++) begin
            bus[32*i +: 32] = (i == ack_slv) ? rdata : (32'hBAD0_0000 | i);
        end
        slv_dout = bus;
        mem_addr = addr;
        mem_wea  = we;
        mem_rea  = re;
        mem_din  = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            slv_ack = (ack_dly >= 0 && c == 1 + ack_dly) ? (4'b0001 << ack_slv) : 4'b0000;
            @(negedge clk);
            if (mem_hold) hold_cnt++;
            if (mmio_err) err_cnt++;
            if ((slv_wen | slv_ren) != 4'b0000) begin
                strb_cnt++;
                saddr_s = slv_addr;
                sdin_s  = slv_din;
            end
            wen_acc |= slv_wen;
            ren_acc |= slv_ren;
            if (c > 0 && !mem_hold) begin
                done   = 1'b1;
                dout_s = mem_dout;
            end
            @(posedge clk);
            #1;
        end
        mem_wea = 1'b0;
        mem_rea = 1'b0;
        slv_ack = 4'b0000;
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_hold"}, hold_cnt, exp_hold);
        check_eq({tag, "_wen"}, 32'(wen_acc), 32'(exp_wen));
        check_eq({tag, "_ren"}, 32'(ren_acc), 32'(exp_ren));
        check_eq({tag, "_strb"}, strb_cnt, ((exp_wen | exp_ren) != 4'b0000) ? 1 : 0);
        check_eq({tag, "_err"}, err_cnt, exp_err ? 1 : 0);
        check_eq({tag, "_dout"}, dout_s, exp_dout);
        if ((exp_wen | exp_ren) != 4'b0000) check_eq({tag, "_saddr"}, 32'(saddr_s), 32'(exp_saddr));
        if (exp_wen != 4'b0000) check_eq({tag, "_sdin"}, sdin_s, wdata);
        @(negedge clk);
        check_eq({tag, "_idle_hold"}, 32'(mem_hold), 32'd0);
        check_eq({tag, "_idle_err"}, 32'(mmio_err), 32'd0);
        check_eq({tag, "_idle_dout"}, mem_dout, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        mem_addr = '0;
        mem_wea  = 1'b0;
        mem_rea  = 1'b0;
        mem_din  = '0;
        slv_dout = '0;
        slv_ack  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_hold", 32'(mem_hold), 32'd0);
        check_eq("rst_err", 32'(mmio_err), 32'd0);
        check_eq("rst_dout", mem_dout, 32'h0);
        check_eq("rst_strb", 32'({slv_wen, slv_ren}), 32'h0);
        check_eq("rst_saddr", 32'(slv_addr), 32'h0);
        check_eq("rst_sdin", slv_din, 32'h0);
        @(posedge clk);
        #1;

        //      tag      addr           we    re    wdata        slv dly rdata        hold wen      ren      err   dout            saddr
        do_txn("rd1",   32'haaaaa104, 1'b0, 1'b1, 32'h0,        1,  0, 32'h41,        2, 4'b0000, 4'b0010, 1'b0, 32'h0000_0041, 8'h04);
        do_txn("wr0",   32'haaaaa008, 1'b1, 1'b0, 32'h55,       0,  3, 32'h0,         5, 4'b0001, 4'b0000, 1'b0, 32'h0,         8'h08);
        do_txn("lane3", 32'haaaaa203, 1'b0, 1'b1, 32'h0,        2,  0, 32'h7A,        2, 4'b0000, 4'b0100, 1'b0, 32'h7A00_0000, 8'h03);
        do_txn("lane1", 32'haaaaa305, 1'b0, 1'b1, 32'h0,        3,  2, 32'hFFFF_FF3C, 4, 4'b0000, 4'b1000, 1'b0, 32'h0000_3C00, 8'h05);
        do_txn("both",  32'haaaaa1FC, 1'b1, 1'b1, 32'h1234,     1,  1, 32'h99,        3, 4'b0010, 4'b0000, 1'b0, 32'h0,         8'hFC);
        do_txn("decerr",32'haaaaa400, 1'b0, 1'b1, 32'h0,        0,  0, 32'h11,        1, 4'b0000, 4'b0000, 1'b1, 32'hFFFF_FFFF, 8'h00);
        do_txn("tmo",   32'haaaaa000, 1'b0, 1'b1, 32'h0,        0, -1, 32'h22,       17, 4'b0000, 4'b0001, 1'b1, 32'hFFFF_FFFF, 8'h00);
        // Ack from a slave other than the addressed one must not complete the access.
        do_txn("wrongack", 32'haaaaa200, 1'b0, 1'b1, 32'h0,     3,  0, 32'h33,       17, 4'b0000, 4'b0100, 1'b1, 32'hFFFF_FFFF, 8'h00);

        // Late ack after the timeout, with no request pending.
        slv_ack = 4'b0001;
        @(negedge clk);
        check_eq("late_hold", 32'(mem_hold), 32'd0);
        @(posedge clk);
        #1;
        slv_ack = 4'b0000;
        @(negedge clk);
        check_eq("late_dout", mem_dout, 32'h0);
        check_eq("late_err", 32'(mmio_err), 32'd0);
        @(posedge clk);
        #1;

        // Reset while a write sits in WAIT.
        mem_addr = 32'haaaaa310;
        mem_din  = 32'hCAFE;
        mem_wea  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mid_hold", 32'(mem_hold), 32'd1);
        check_eq("mid_sdin", slv_din, 32'hCAFE);
        @(posedge clk);
        #1;
        mem_wea = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        slv_ack = 4'b1000;
        @(negedge clk);
        check_eq("mrst_hold", 32'(mem_hold), 32'd0);
        check_eq("mrst_strb", 32'({slv_wen, slv_ren}), 32'h0);
        check_eq("mrst_saddr", 32'(slv_addr), 32'h0);
        check_eq("mrst_sdin", slv_din, 32'h0);
        check_eq("mrst_dout", mem_dout, 32'h0);
        @(posedge clk);
        #1;
        slv_ack = 4'b0000;
        @(negedge clk);
        check_eq("mrst_ack_dout", mem_dout, 32'h0);
        check_eq("mrst_ack_err", 32'(mmio_err), 32'd0);
        @(posedge clk);
        #1;

        // Non-MMIO access is not ours.
        mem_addr = 32'h0001_0000;
        mem_rea  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("nonmmio_hold", 32'(mem_hold), 32'd0);
            check_eq("nonmmio_strb", 32'({slv_wen, slv_ren}), 32'h0);
            @(posedge clk);
            #1;
        end
        mem_rea = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
